mem_arbiter: RTL and testbench

Sequences and shares the single system memory port (BIOS ROM, internal RAM, pak RAM, VRAM write path) between three requesters: DMA, CPU data and CPU instruction fetch. Each granted access is driven on the memory port and its read data is captured and returned. The block sits between the CPU/DMA units and the memory decoder. It converts their independent request lines into non-overlapping read/write cycles that respect the memory's one-cycle synchronous read latency and its `ok` stall signal.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants and state type for the memory port arbiter
package mem_arb_pkg;

    localparam int N_PORTS    = 3;
    localparam int PORT_DMA   = 0;
    localparam int PORT_DATA  = 1;
    localparam int PORT_FETCH = 2;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_COMPLETE
    } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - fixed DMA priority with 2-way round-robin between the CPU ports
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [N_PORTS-1:0] req_i,
    input  logic               rot_i,
    output logic [N_PORTS-1:0] win_o
);

    // rot_i=0 favours the data port, rot_i=1 favours the fetch port on a tie
    always_comb begin
        win_o = '0;
        if (req_i[PORT_DMA]) begin
            win_o[PORT_DMA] = 1'b1;
        end else if (req_i[PORT_DATA] && req_i[PORT_FETCH]) begin
            if (rot_i) begin
                win_o[PORT_FETCH] = 1'b1;
            end else begin
                win_o[PORT_DATA] = 1'b1;
            end
        end else if (req_i[PORT_DATA]) begin
            win_o[PORT_DATA] = 1'b1;
        end else if (req_i[PORT_FETCH]) begin
            win_o[PORT_FETCH] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the single synchronous memory port between DMA, CPU data and CPU fetch
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS*ADDR_W-1:0] req_addr,
    input  logic [N_PORTS*DATA_W-1:0] req_wdata,
    input  logic [2*N_PORTS-1:0]      req_width,
    input  logic [N_PORTS-1:0]        req_we,
    input  logic                      dma_lock,
    output logic [N_PORTS-1:0]        gnt,
    output logic [N_PORTS-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [1:0]                mem_width,
    output logic                      mem_read,
    output logic                      mem_write,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ok
);

    arb_state_e          state_q;
    logic                rot_q;
    logic [1:0]          cur_idx_q;
    logic [N_PORTS-1:0]  done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [1:0]          mem_width_q;
    logic                mem_read_q;
    logic                mem_write_q;

    logic [N_PORTS-1:0]  req_m;
    logic [N_PORTS-1:0]  win;
    logic [1:0]          sel_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [1:0]          sel_width;
    logic                sel_we;
    logic [DATA_W-1:0]   rdata_d;

    // the lock only holds off the CPU ports; DMA still arbitrates normally
    assign req_m = {req[PORT_FETCH] & ~dma_lock, req[PORT_DATA] & ~dma_lock, req[PORT_DMA]};

    mem_arb_pick u_pick (
        .req_i (req_m),
        .rot_i (rot_q),
        .win_o (win)
    );

    assign gnt = (state_q == S_IDLE && !rst) ? win : '0;

    always_comb begin
        sel_idx   = 2'(PORT_FETCH);
        sel_addr  = req_addr[PORT_FETCH*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[PORT_FETCH*DATA_W +: DATA_W];
        sel_width = req_width[PORT_FETCH*2 +: 2];
        sel_we    = req_we[PORT_FETCH];
        if (win[PORT_DMA]) begin
            sel_idx   = 2'(PORT_DMA);
            sel_addr  = req_addr[PORT_DMA*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[PORT_DMA*DATA_W +: DATA_W];
            sel_width = req_width[PORT_DMA*2 +: 2];
            sel_we    = req_we[PORT_DMA];
        end else if (win[PORT_DATA]) begin
            sel_idx   = 2'(PORT_DATA);
            sel_addr  = req_addr[PORT_DATA*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[PORT_DATA*DATA_W +: DATA_W];
            sel_width = req_width[PORT_DATA*2 +: 2];
            sel_we    = req_we[PORT_DATA];
        end
    end

    always_comb begin
        case (mem_width_q)
            W_BYTE:  rdata_d = {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
            W_HALF:  rdata_d = {{(DATA_W-16){1'b0}}, mem_rdata[15:0]};
            default: rdata_d = mem_rdata;
        endcase
    end

    // mem_* registers double as the latched request; mem_write_q is the current we
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rot_q       <= 1'b0;
            cur_idx_q   <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_width_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (|win) begin
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        mem_width_q <= (sel_width == 2'd3) ? W_WORD : sel_width;
                        mem_read_q  <= ~sel_we;
                        mem_write_q <= sel_we;
                        cur_idx_q   <= sel_idx;
                        if (win[PORT_DATA]) begin
                            rot_q <= 1'b1;
                        end else if (win[PORT_FETCH]) begin
                            rot_q <= 1'b0;
                        end
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_ok) begin
                        if (mem_write_q) begin
                            done_q      <= 3'b001 << cur_idx_q;
                            mem_write_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            state_q <= S_COMPLETE;
                        end
                    end
                end
                S_COMPLETE: begin
                    // address and read strobe stay up while the memory lane-shifts its output
                    if (mem_ok) begin
                        rdata_q    <= rdata_d;
                        done_q     <= 3'b001 << cur_idx_q;
                        mem_read_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign done      = done_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_width = mem_width_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for the memory port arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [95:0] req_addr;
    logic [95:0] req_wdata;
    logic [5:0]  req_width;
    logic [2:0]  req_we;
    logic        dma_lock;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_width;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ok;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  oh;
        logic [31:0] rd;
    } exp_t;

    logic [2:0]  gq[$];
    exp_t        dq[$];
    logic [31:0] model_rdata = 32'h0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_width (req_width),
        .req_we    (req_we),
        .dma_lock  (dma_lock),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_width (mem_width),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .mem_ok    (mem_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every grant and every completion is popped against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt != 3'b000) begin
                if (gq.size() == 0) begin
                    chk("sb_gnt_unexpected", 32'(gnt), 32'h0);
                end else begin
                    chk("sb_gnt", 32'(gnt), 32'(gq.pop_front()));
                end
            end
            if (done != 3'b000) begin
                if (dq.size() == 0) begin
                    chk("sb_done_unexpected", 32'(done), 32'h0);
                end else begin
                    exp_t e;
                    e = dq.pop_front();
                    chk("sb_done", 32'(done), 32'(e.oh));
                    chk("sb_rdata", rdata, e.rd);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slice(input int p, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] w, input logic we);
        req_addr[p*32 +: 32]  = a;
        req_wdata[p*32 +: 32] = wd;
        req_width[p*2 +: 2]   = w;
        req_we[p]             = we;
    endtask

    task automatic do_read(input int p, input logic [31:0] a, input logic [1:0] w,
                           input logic [31:0] mrd, input logic [31:0] exp);
        logic [2:0] oh;
        oh = 3'b001 << p;
        next_cycle();
        set_slice(p, a, 32'h0, w, 1'b0);
        req[p]    = 1'b1;
        mem_rdata = mrd;
        mem_ok    = 1'b1;
        gq.push_back(oh);
        dq.push_back('{oh, exp});
        model_rdata = exp;
        @(negedge clk);
        chk("rd_gnt", 32'(gnt), 32'(oh));
        chk("rd_idle_strobe", 32'(mem_read), 32'h0);
        next_cycle();
        req[p] = 1'b0;
        @(negedge clk);
        chk("rd_strobe1", 32'(mem_read), 32'h1);
        chk("rd_nowrite", 32'(mem_write), 32'h0);
        chk("rd_addr", mem_addr, a);
        next_cycle();
        @(negedge clk);
        chk("rd_strobe2", 32'(mem_read), 32'h1);
        chk("rd_addr_hold", mem_addr, a);
        next_cycle();
        @(negedge clk);
        chk("rd_done", 32'(done), 32'(oh));
        chk("rd_data", rdata, exp);
        chk("rd_strobe_off", 32'(mem_read), 32'h0);
    endtask

    task automatic do_write(input int p, input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] w, input int stalls);
        logic [2:0] oh;
        oh = 3'b001 << p;
        next_cycle();
        set_slice(p, a, wd, w, 1'b1);
        req[p] = 1'b1;
        mem_ok = 1'b1;
        gq.push_back(oh);
        dq.push_back('{oh, model_rdata});
        @(negedge clk);
        chk("wr_gnt", 32'(gnt), 32'(oh));
        for (int j = 1; j <= stalls + 1; j++) begin
            next_cycle();
            if (j == 1) req[p] = 1'b0;
            mem_ok = (j == stalls + 1);
            @(negedge clk);
            chk("wr_strobe", 32'(mem_write), 32'h1);
            chk("wr_noread", 32'(mem_read), 32'h0);
            chk("wr_addr", mem_addr, a);
            chk("wr_data", mem_wdata, wd);
            chk("wr_nodone", 32'(done), 32'h0);
        end
        next_cycle();
        mem_ok = 1'b1;
        @(negedge clk);
        chk("wr_done", 32'(done), 32'(oh));
        chk("wr_strobe_off", 32'(mem_write), 32'h0);
    endtask

    function automatic logic [2:0] cont_gnt(input int c);
        case (c)
            0, 3, 6, 9: return 3'b001;
            12, 18:     return 3'b010;
            15:         return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req       = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        req_width = '0;
        req_we    = '0;
        dma_lock  = 1'b0;
        mem_rdata = 32'h0;
        mem_ok    = 1'b1;

        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_width", 32'(mem_width), 32'h0);
        chk("rst_read", 32'(mem_read), 32'h0);
        chk("rst_write", 32'(mem_write), 32'h0);
        next_cycle();
        rst = 1'b0;

        // contention: DMA dominates, then the CPU ports alternate starting with data
        next_cycle();
        for (int p = 0; p < 3; p++) set_slice(p, 32'h1000_0000 + 32'(p) * 32'h100, 32'h0, 2'd2, 1'b0);
        req       = 3'b111;
        mem_rdata = 32'hCAFE_F00D;
        for (int k = 0; k < 4; k++) begin
            gq.push_back(3'b001);
            dq.push_back('{3'b001, 32'hCAFE_F00D});
        end
        gq.push_back(3'b010); dq.push_back('{3'b010, 32'hCAFE_F00D});
        gq.push_back(3'b100); dq.push_back('{3'b100, 32'hCAFE_F00D});
        gq.push_back(3'b010); dq.push_back('{3'b010, 32'hCAFE_F00D});
        model_rdata = 32'hCAFE_F00D;
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) next_cycle();
            if (c == 12) req[0] = 1'b0;
            if (c == 19) req = 3'b000;
            @(negedge clk);
            chk($sformatf("cont_gnt_c%0d", c), 32'(gnt), 32'(cont_gnt(c)));
        end

        do_read(1, 32'h0300_0004, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_read(1, 32'h0300_0005, 2'd0, 32'h1234_56A5, 32'h0000_00A5);
        do_read(1, 32'h0300_0006, 2'd1, 32'h1234_56A5, 32'h0000_56A5);

        // dma_lock hides the CPU requests until DMA itself asks
        next_cycle();
        dma_lock = 1'b1;
        set_slice(1, 32'h0300_0100, 32'h0, 2'd2, 1'b0);
        set_slice(2, 32'h0300_0200, 32'h0, 2'd2, 1'b0);
        req = 3'b110;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            chk("lock_gnt", 32'(gnt), 32'h0);
            chk("lock_read", 32'(mem_read), 32'h0);
            chk("lock_write", 32'(mem_write), 32'h0);
        end
        next_cycle();
        set_slice(0, 32'h0000_0040, 32'h0, 2'd2, 1'b0);
        req[0]    = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        gq.push_back(3'b001);
        dq.push_back('{3'b001, 32'h0BAD_F00D});
        model_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("lock_dma_gnt", 32'(gnt), 32'h1);
        next_cycle();
        req[0] = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("lock_dma_done", 32'(done), 32'h1);
        next_cycle();
        req      = 3'b000;
        dma_lock = 1'b0;

        do_write(1, 32'h0600_0010, 32'hA1B2_C3D4, 2'd2, 4);
        do_write(2, 32'h0700_0002, 32'h0000_BEEF, 2'd1, 0);
        do_read(2, 32'h0000_0100, 2'd3, 32'h8765_4321, 32'h8765_4321);

        // reset while a read sits in COMPLETE: no done, everything cleared
        next_cycle();
        set_slice(1, 32'h0300_0020, 32'h0, 2'd2, 1'b0);
        req[1]    = 1'b1;
        mem_rdata = 32'h55AA_55AA;
        gq.push_back(3'b010);
        @(negedge clk);
        chk("abort_gnt", 32'(gnt), 32'h2);
        next_cycle();
        req[1] = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        model_rdata = 32'h0;
        @(negedge clk);
        chk("abort_gnt0", 32'(gnt), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_addr", mem_addr, 32'h0);
        chk("abort_wdata", mem_wdata, 32'h0);
        chk("abort_width", 32'(mem_width), 32'h0);
        chk("abort_read", 32'(mem_read), 32'h0);
        chk("abort_write", 32'(mem_write), 32'h0);

        // rotation restarts favouring the data port
        next_cycle();
        set_slice(1, 32'h0300_0030, 32'h0, 2'd2, 1'b0);
        set_slice(2, 32'h0300_0040, 32'h0, 2'd1, 1'b0);
        req       = 3'b110;
        mem_rdata = 32'h89AB_CDEF;
        gq.push_back(3'b010); dq.push_back('{3'b010, 32'h89AB_CDEF});
        gq.push_back(3'b100); dq.push_back('{3'b100, 32'h0000_CDEF});
        model_rdata = 32'h0000_CDEF;
        @(negedge clk);
        chk("rot_first", 32'(gnt), 32'h2);
        next_cycle();
        req[1] = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rot_second", 32'(gnt), 32'h4);
        chk("rot_done1", 32'(done), 32'h2);
        next_cycle();
        req[2] = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rot_done2", 32'(done), 32'h4);
        chk("rot_rdata2", rdata, 32'h0000_CDEF);

        do_read(0, 32'h0000_0003, 2'd0, 32'hFFFF_FF7E, 32'h0000_007E);

        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("sb_gnt_drain", 32'(gq.size()), 32'h0);
        chk("sb_done_drain", 32'(dq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
